// File: rtl/stream_pkg.sv
// ---------------------------------------------------------------------------
// stream_pkg
// Shared definitions for the frame streamer slice:
//   - default pixel width and frame dimensions
//   - controller state encoding
//   - clog2 helper used to size counters and pointers
// ---------------------------------------------------------------------------
package stream_pkg;

    localparam int PIXEL_BITS     = 8;
    localparam int DEFAULT_WIDTH  = 320;
    localparam int DEFAULT_HEIGHT = 240;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } stream_state_e;

    // Never returns less than 1 so a degenerate dimension still gets a real bit.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/frame_streamer_if.sv
// ---------------------------------------------------------------------------
// frame_streamer_if
// Bundles the memory read bus and the outgoing pixel stream.
//   master (streamer) : drives mem_addr/mem_read and shift/pix_out/col/row/eol/eof,
//                       receives mem_waitrequest/mem_readdatavalid/mem_readdata/out_ready
//   slave  (memory + downstream) : the mirror image
// ---------------------------------------------------------------------------
interface frame_streamer_if
    import stream_pkg::*;
#(
    parameter int NUM_BITS  = PIXEL_BITS,
    parameter int ADDR_BITS = 17,
    parameter int COL_BITS  = clog2(DEFAULT_WIDTH),
    parameter int ROW_BITS  = clog2(DEFAULT_HEIGHT)
);
    logic [ADDR_BITS-1:0] mem_addr;
    logic                 mem_read;
    logic                 mem_waitrequest;
    logic                 mem_readdatavalid;
    logic [NUM_BITS-1:0]  mem_readdata;
    logic                 out_ready;
    logic                 shift;
    logic [NUM_BITS-1:0]  pix_out;
    logic [COL_BITS-1:0]  col;
    logic [ROW_BITS-1:0]  row;
    logic                 eol;
    logic                 eof;

    modport master (
        output mem_addr, mem_read,
        input  mem_waitrequest, mem_readdatavalid, mem_readdata,
        input  out_ready,
        output shift, pix_out, col, row, eol, eof
    );

    modport slave (
        input  mem_addr, mem_read,
        output mem_waitrequest, mem_readdatavalid, mem_readdata,
        output out_ready,
        input  shift, pix_out, col, row, eol, eof
    );
endinterface

// File: rtl/pixel_fifo.sv
// ---------------------------------------------------------------------------
// pixel_fifo
// Small synchronous FIFO absorbing memory read latency.
//   clk, reset : clock, synchronous active-high reset (empties the FIFO)
//   push/push_data : write a pixel
//   pop        : consume head
//   head       : current head; when empty it shows push_data so that a push
//                and pop in the same cycle pass straight through
//   count, empty, full : occupancy status
// ---------------------------------------------------------------------------
module pixel_fifo
    import stream_pkg::*;
#(
    parameter int NUM_BITS   = PIXEL_BITS,
    parameter int FIFO_DEPTH = 4,
    localparam int PTR_BITS  = clog2(FIFO_DEPTH),
    localparam int CNT_BITS  = PTR_BITS + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                push,
    input  logic [NUM_BITS-1:0] push_data,
    input  logic                pop,
    output logic [NUM_BITS-1:0] head,
    output logic [CNT_BITS-1:0] count,
    output logic                empty,
    output logic                full
);
    logic [NUM_BITS-1:0] storage_q [FIFO_DEPTH];
    logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_BITS-1:0] count_q, count_d;
    logic                through;
    logic                do_push;
    logic                do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_BITS'(FIFO_DEPTH));
    assign count = count_q;
    assign head  = empty ? push_data : storage_q[rd_ptr_q];

    // Push+pop on an empty FIFO never touches storage; push+pop on a full one
    // overwrites the slot being read this same cycle. Depth is a power of two,
    // so pointers wrap naturally.
    always_comb begin
        through  = empty && push && pop;
        do_push  = push && !through && (!full || pop);
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_BITS'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_BITS'(1);
        if (do_push && !do_pop)      count_d = count_q + CNT_BITS'(1);
        else if (!do_push && do_pop) count_d = count_q - CNT_BITS'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) storage_q[wr_ptr_q] <= push_data;
    end
endmodule

// File: rtl/frame_streamer.sv
// ---------------------------------------------------------------------------
// frame_streamer
// Reads one WIDTH x HEIGHT frame from memory in raster order and emits one
// pixel per shift strobe under downstream backpressure.
//   clk, reset : clock, synchronous active-high reset
//   start      : begin a frame (only honoured in IDLE)
//   busy       : frame in progress (READ or DRAIN)
//   done       : one-cycle pulse after the last pixel was shifted
//   bus        : memory read master + pixel stream (frame_streamer_if.master)
// ---------------------------------------------------------------------------
module frame_streamer
    import stream_pkg::*;
#(
    parameter int NUM_BITS   = PIXEL_BITS,
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int HEIGHT     = DEFAULT_HEIGHT,
    parameter int ADDR_BITS  = 17,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    frame_streamer_if.master        bus
);
    localparam int COL_BITS = clog2(WIDTH);
    localparam int ROW_BITS = clog2(HEIGHT);
    localparam int CNT_BITS = clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(WIDTH * HEIGHT - 1);
    localparam logic [COL_BITS-1:0]  LAST_COL  = COL_BITS'(WIDTH - 1);
    localparam logic [ROW_BITS-1:0]  LAST_ROW  = ROW_BITS'(HEIGHT - 1);

    stream_state_e        state_q, state_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [CNT_BITS-1:0]  outstanding_q, outstanding_d;
    logic                 shift_q, shift_d;
    logic [NUM_BITS-1:0]  pix_q, pix_d;
    logic [COL_BITS-1:0]  col_q, col_d, next_col_q, next_col_d;
    logic [ROW_BITS-1:0]  row_q, row_d, next_row_q, next_row_d;
    logic                 eol_q, eol_d, eof_q, eof_d;

    logic                 active;
    logic                 ret_valid;
    logic                 read_req;
    logic                 accept;
    logic [CNT_BITS:0]    credit_used;
    logic                 fifo_push, fifo_pop, fifo_empty, fifo_full;
    logic [NUM_BITS-1:0]  fifo_head;
    logic [CNT_BITS-1:0]  fifo_count;

    pixel_fifo #(.NUM_BITS(NUM_BITS), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .reset(reset),
        .push(fifo_push), .push_data(bus.mem_readdata),
        .pop(fifo_pop), .head(fifo_head),
        .count(fifo_count), .empty(fifo_empty), .full(fifo_full)
    );

    // Returns are only trusted while a frame is running and a request is in
    // flight, which throws away stale data still arriving after a reset.
    // Credit counts outstanding reads plus buffered pixels; since it only
    // shrinks while waitrequest holds, mem_read stays stable during a stall.
    always_comb begin
        active      = (state_q == ST_READ) || (state_q == ST_DRAIN);
        ret_valid   = active && bus.mem_readdatavalid && (outstanding_q != '0);
        credit_used = {1'b0, outstanding_q} + {1'b0, fifo_count};
        read_req    = (state_q == ST_READ) && (credit_used < (CNT_BITS + 1)'(FIFO_DEPTH));
        accept      = read_req && !bus.mem_waitrequest;
        fifo_push   = ret_valid;
        fifo_pop    = active && bus.out_ready && (!fifo_empty || ret_valid);
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        outstanding_d = outstanding_q;
        shift_d       = 1'b0;
        eol_d         = 1'b0;
        eof_d         = 1'b0;
        pix_d         = pix_q;
        col_d         = col_q;
        row_d         = row_q;
        next_col_d    = next_col_q;
        next_row_d    = next_row_q;

        if (accept && !ret_valid)      outstanding_d = outstanding_q + CNT_BITS'(1);
        else if (!accept && ret_valid) outstanding_d = outstanding_q - CNT_BITS'(1);

        // next_col/next_row track the position of the pixel about to be popped.
        if (fifo_pop) begin
            shift_d = 1'b1;
            pix_d   = fifo_head;
            col_d   = next_col_q;
            row_d   = next_row_q;
            eol_d   = (next_col_q == LAST_COL);
            eof_d   = (next_col_q == LAST_COL) && (next_row_q == LAST_ROW);
            if (next_col_q == LAST_COL) begin
                next_col_d = '0;
                next_row_d = next_row_q + ROW_BITS'(1);
            end else begin
                next_col_d = next_col_q + COL_BITS'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d       = ST_READ;
                    addr_d        = '0;
                    outstanding_d = '0;
                    next_col_d    = '0;
                    next_row_d    = '0;
                end
            end
            ST_READ: begin
                if (accept) begin
                    if (addr_q == LAST_ADDR) state_d = ST_DRAIN;
                    else                     addr_d  = addr_q + ADDR_BITS'(1);
                end
            end
            ST_DRAIN: begin
                if (shift_q && eof_q) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            outstanding_q <= '0;
            shift_q       <= 1'b0;
            pix_q         <= '0;
            col_q         <= '0;
            row_q         <= '0;
            eol_q         <= 1'b0;
            eof_q         <= 1'b0;
            next_col_q    <= '0;
            next_row_q    <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            outstanding_q <= outstanding_d;
            shift_q       <= shift_d;
            pix_q         <= pix_d;
            col_q         <= col_d;
            row_q         <= row_d;
            eol_q         <= eol_d;
            eof_q         <= eof_d;
            next_col_q    <= next_col_d;
            next_row_q    <= next_row_d;
        end
    end

    fifo_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(fifo_push && fifo_full && !fifo_pop));

    assign busy         = (state_q == ST_READ) || (state_q == ST_DRAIN);
    assign done         = (state_q == ST_DONE);
    assign bus.mem_addr = addr_q;
    assign bus.mem_read = read_req;
    assign bus.shift    = shift_q;
    assign bus.pix_out  = pix_q;
    assign bus.col      = col_q;
    assign bus.row      = row_q;
    assign bus.eol      = eol_q;
    assign bus.eof      = eof_q;
endmodule

// File: tb/tb_frame_streamer.sv
// ---------------------------------------------------------------------------
// tb_frame_streamer
// Directed bench for a 4x2 frame with a 4-deep FIFO. A negedge process plays
// the memory (mem[i] = i + 16, configurable latency and stall) and logs every
// shift; the initial block runs the directed steps and compares the log.
// ---------------------------------------------------------------------------
module tb_frame_streamer;
    localparam int NB = 8;
    localparam int W  = 4;
    localparam int H  = 2;
    localparam int AB = 17;
    localparam int FD = 4;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic busy;
    logic done;

    frame_streamer_if #(.NUM_BITS(NB), .ADDR_BITS(AB), .COL_BITS(2), .ROW_BITS(1)) bus ();

    frame_streamer #(.NUM_BITS(NB), .WIDTH(W), .HEIGHT(H), .ADDR_BITS(AB), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] pix;
        int         col;
        int         row;
        logic       eol;
        logic       eof;
        int         cyc;
    } shift_rec_t;

    typedef struct {
        int         due;
        logic [7:0] data;
    } ret_t;

    shift_rec_t shiftLog[$];
    ret_t       pending[$];
    int cycle, accCount, maxInflight, doneCount, lastDoneCycle;
    int shiftOutsideBusy, shiftNotReady, readLowCycles;
    int stallLeft, stallCycles, stallBad, staleLeft, memLatency, stallAddr;
    bit stallActive;
    int totalChecks, badChecks;
    bit readyPattern[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    // Memory model and stream monitor, evaluated mid-cycle. Whatever is driven
    // here is what the DUT samples at the next rising edge.
    always @(negedge clk) begin
        cycle = cycle + 1;
        if (!reset) begin
            if (bus.shift) begin
                shiftLog.push_back('{bus.pix_out, int'(bus.col), int'(bus.row), bus.eol, bus.eof, cycle});
                if (!busy) shiftOutsideBusy = shiftOutsideBusy + 1;
                if (!bus.out_ready) shiftNotReady = shiftNotReady + 1;
            end
            if (done) begin
                doneCount     = doneCount + 1;
                lastDoneCycle = cycle;
            end
            if (accCount - shiftLog.size() > maxInflight) maxInflight = accCount - shiftLog.size();
        end
        if (staleLeft > 0) begin
            bus.mem_readdatavalid = 1'b1;
            bus.mem_readdata      = 8'hEE;
            staleLeft             = staleLeft - 1;
        end else if (pending.size() > 0 && pending[0].due == cycle) begin
            bus.mem_readdatavalid = 1'b1;
            bus.mem_readdata      = pending[0].data;
            void'(pending.pop_front());
        end else begin
            bus.mem_readdatavalid = 1'b0;
            bus.mem_readdata      = 8'h00;
        end
        if (stallLeft > 0 && (stallActive || (bus.mem_read && int'(bus.mem_addr) == stallAddr))) begin
            stallActive         = 1'b1;
            bus.mem_waitrequest = 1'b1;
            if (!(bus.mem_read && int'(bus.mem_addr) == stallAddr)) stallBad = stallBad + 1;
            stallLeft   = stallLeft - 1;
            stallCycles = stallCycles + 1;
        end else begin
            stallActive         = 1'b0;
            bus.mem_waitrequest = 1'b0;
        end
        if (!reset && busy && !bus.mem_read && accCount < W * H) readLowCycles = readLowCycles + 1;
        if (!reset && bus.mem_read && !bus.mem_waitrequest) begin
            pending.push_back('{cycle + memLatency, 8'(int'(bus.mem_addr) + 16)});
            accCount = accCount + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalChecks = totalChecks + 1;
        assert (observed === expected) else begin
            badChecks = badChecks + 1;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #2;
        end
    endtask

    // Runs one frame; stops at done, or after abortAfter shifts when nonzero.
    task automatic applyStimulus(input string tag, input int latency, input int stallAt,
                                 input bit toggleReady, input bit extraStart, input int abortAfter);
        bit finished;
        shiftLog.delete();
        pending.delete();
        accCount = 0; maxInflight = 0; doneCount = 0; lastDoneCycle = 0;
        shiftOutsideBusy = 0; shiftNotReady = 0; readLowCycles = 0;
        stallCycles = 0; stallBad = 0; stallActive = 1'b0;
        memLatency = latency;
        stallAddr  = stallAt;
        stallLeft  = (stallAt >= 0) ? 3 : 0;
        finished   = 1'b0;
        start         = 1'b1;
        bus.out_ready = 1'b1;
        for (int n = 1; n < 300; n++) begin
            @(negedge clk);
            #2;
            start = extraStart && (n == 4);
            if (toggleReady) bus.out_ready = readyPattern[n % 4];
            if (abortAfter > 0 ? (shiftLog.size() >= abortAfter) : (doneCount > 0)) begin
                finished = 1'b1;
                break;
            end
        end
        checkOutput({tag, "_finished"}, 32'(finished), 32'd1);
        if (extraStart && finished) begin
            start = 1'b1;
            waitCycles(1);
            start = 1'b0;
        end
        bus.out_ready = 1'b1;
    endtask

    task automatic verifyFrame(input string tag);
        checkOutput({tag, "_count"}, 32'(shiftLog.size()), 32'(W * H));
        for (int i = 0; i < shiftLog.size() && i < W * H; i++) begin
            checkOutput($sformatf("%s_pix%0d", tag, i), 32'(shiftLog[i].pix), 32'(16 + i));
            checkOutput($sformatf("%s_col%0d", tag, i), 32'(shiftLog[i].col), 32'(i % W));
            checkOutput($sformatf("%s_row%0d", tag, i), 32'(shiftLog[i].row), 32'(i / W));
            checkOutput($sformatf("%s_eol%0d", tag, i), 32'(shiftLog[i].eol), 32'(i % W == W - 1));
            checkOutput($sformatf("%s_eof%0d", tag, i), 32'(shiftLog[i].eof), 32'(i == W * H - 1));
        end
        checkOutput({tag, "_outside_busy"}, 32'(shiftOutsideBusy), 32'd0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_mem_read"}, 32'(bus.mem_read), 32'd0);
        checkOutput({tag, "_shift"}, 32'(bus.shift), 32'd0);
        checkOutput({tag, "_eol"}, 32'(bus.eol), 32'd0);
        checkOutput({tag, "_eof"}, 32'(bus.eof), 32'd0);
        checkOutput({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
        checkOutput({tag, "_pix_out"}, 32'(bus.pix_out), 32'd0);
        checkOutput({tag, "_col"}, 32'(bus.col), 32'd0);
        checkOutput({tag, "_row"}, 32'(bus.row), 32'd0);
    endtask

    initial begin
        reset         = 1'b1;
        start         = 1'b1;
        bus.out_ready = 1'b1;
        memLatency    = 1;
        stallAddr     = -1;
        waitCycles(3);
        checkResetValues("reset");
        reset = 1'b0;
        start = 1'b0;
        waitCycles(2);

        $display("[TB] step 1: zero-wait memory, latency 1");
        applyStimulus("basic", 1, -1, 1'b0, 1'b0, 0);
        waitCycles(3);
        verifyFrame("basic");
        if (shiftLog.size() == W * H) begin
            checkOutput("basic_back_to_back", 32'(shiftLog[W * H - 1].cyc - shiftLog[0].cyc), 32'(W * H - 1));
            checkOutput("basic_done_timing", 32'(lastDoneCycle), 32'(shiftLog[W * H - 1].cyc + 1));
        end
        checkOutput("basic_done_count", 32'(doneCount), 32'd1);
        checkOutput("basic_idle_busy", 32'(busy), 32'd0);

        $display("[TB] step 2: latency 6 against a 4-deep credit window");
        applyStimulus("lat6", 6, -1, 1'b0, 1'b0, 0);
        waitCycles(3);
        verifyFrame("lat6");
        checkOutput("lat6_max_inflight", 32'(maxInflight), 32'd4);

        $display("[TB] step 3: waitrequest held 3 cycles on address 5");
        applyStimulus("stall", 1, 5, 1'b0, 1'b0, 0);
        waitCycles(3);
        verifyFrame("stall");
        checkOutput("stall_cycles", 32'(stallCycles), 32'd3);
        checkOutput("stall_unstable", 32'(stallBad), 32'd0);

        $display("[TB] step 4: out_ready pattern 1,0,0,1");
        applyStimulus("ready", 1, -1, 1'b1, 1'b0, 0);
        waitCycles(3);
        verifyFrame("ready");
        checkOutput("ready_shift_without_ready", 32'(shiftNotReady), 32'd0);
        checkOutput("ready_max_inflight", 32'(maxInflight), 32'd4);
        checkOutput("ready_credit_stall", 32'(readLowCycles > 0), 32'd1);

        $display("[TB] step 5: reset after 3 shifts with stale returns");
        applyStimulus("abort", 1, -1, 1'b0, 1'b0, 3);
        reset = 1'b1;
        pending.delete();
        staleLeft = 2;
        waitCycles(1);
        checkResetValues("midreset");
        reset = 1'b0;
        waitCycles(4);
        checkOutput("midreset_no_more_shifts", 32'(shiftLog.size()), 32'd3);
        checkOutput("midreset_idle", 32'(busy), 32'd0);
        applyStimulus("restart", 1, -1, 1'b0, 1'b0, 0);
        waitCycles(3);
        verifyFrame("restart");
        checkOutput("restart_done_count", 32'(doneCount), 32'd1);

        $display("[TB] step 6: start pulsed while busy and during done");
        applyStimulus("busy_start", 1, -1, 1'b0, 1'b1, 0);
        waitCycles(4);
        verifyFrame("busy_start");
        checkOutput("busy_start_done_count", 32'(doneCount), 32'd1);
        checkOutput("busy_start_idle", 32'(busy), 32'd0);
        checkOutput("busy_start_no_read", 32'(bus.mem_read), 32'd0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end
endmodule

// File: doc/frame_streamer.md
Name: frame_streamer

Overview:
- Producer end of the streaming pixel path: reads one frame from the frame-buffer memory in raster order.
- Drives the shift/pixel pair consumed by the shift-register line buffers and the census/convolution windows.
- Issues pipelined memory reads, absorbs variable read latency in a small FIFO, and emits one pixel per shift strobe under downstream backpressure.

Parameters:
- NUM_BITS, 8: pixel width.
- WIDTH, 320: pixels per row.
- HEIGHT, 240: rows per frame.
- ADDR_BITS, 17: memory word address width; must be ≥ clog2(WIDTH*HEIGHT).
- FIFO_DEPTH, 4: elastic buffer depth and read-credit limit; power of two, ≥2.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- reset  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse that begins a frame; ignored unless IDLE.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last pixel is shifted.
- mem_addr  out  ADDR_BITS  read word address, base 0.
- mem_read  out  1  read request.
- mem_waitrequest  in  1  memory stall; request held while high.
- mem_readdatavalid  in  1  return data valid.
- mem_readdata  in  NUM_BITS  returned pixel.
- out_ready  in  1  downstream may accept a pixel this cycle.
- shift  out  1  pixel strobe; drives the line buffers' shift.
- pix_out  out  NUM_BITS  pixel, valid when shift=1.
- col  out  clog2(WIDTH)  column of pix_out.
- row  out  clog2(HEIGHT)  row of pix_out.
- eol  out  1  shift on last column.
- eof  out  1  shift on last pixel of the frame.

Behaviour:
- Reset values: busy, done, mem_read, shift, eol, eof = 0; mem_addr, pix_out, col, row = 0.
  - FIFO emptied; credit counter = 0; state IDLE.
- States:
  - IDLE: start → READ.
  - READ: issuing requests; last request accepted → DRAIN.
  - DRAIN: wait for all returns and shifts; last pixel shifted → DONE.
  - DONE: one cycle, done=1 → IDLE.
- Request rules:
  - A request is accepted when mem_read=1 and mem_waitrequest=0.
  - While mem_waitrequest=1, mem_addr and mem_read stay stable.
  - mem_read is asserted only if outstanding + fifo_count < FIFO_DEPTH, counting a request accepted this cycle.
  - mem_addr increments by 1 per accepted request, from 0 to WIDTH*HEIGHT-1. Use an incrementer, no multiplier.
- Returns:
  - mem_readdatavalid pushes mem_readdata into the FIFO and decrements outstanding.
  - The credit rule guarantees the FIFO never overflows. Overflow is an assertion failure.
  - mem_readdatavalid in IDLE or DONE is dropped, so stale returns after a reset are discarded.
- Output stage (registered):
  - Each cycle, if the FIFO is non-empty and out_ready=1: pop, shift=1 next cycle, pix_out = head; otherwise shift=0.
  - pix_out holds its last value when shift=0.
  - Minimum latency from readdatavalid to shift is 1 cycle.
  - Sustained throughput is 1 pixel/clk when memory latency < FIFO_DEPTH and out_ready=1.
- col/row: update with each shift; col wraps WIDTH-1→0 and row increments. eol/eof are asserted together with the corresponding shift.
- Simultaneous push and pop on a full or empty FIFO is legal; the count is unchanged.
- Exactly WIDTH*HEIGHT shifts per frame. shift never asserts outside busy.
- start while busy or in DONE is ignored. start coincident with reset: reset wins.
- Reset mid-frame: all state returns to reset values on the next edge with no further shift. A subsequent start restarts at address 0.

Decomposition:
- Shared package stream_pkg:
  - pixel width constant and default frame dimensions.
  - state encoding constants (IDLE, READ, DRAIN, DONE).
  - clog2 helper function.
- One sub-module: pixel_fifo (synchronous FIFO with NUM_BITS and FIFO_DEPTH parameters, push/pop/count/empty/full, synchronous active-high reset).
- Credit logic and counters stay in the top level.

Test Plan:
- WIDTH=4, HEIGHT=2, zero-wait memory with 1-cycle latency, out_ready=1, mem[i]=i+16 → 8 consecutive shifts with pix_out 16..23; eol on 19 and 23, eof on 23; done one cycle after the last shift.
- Memory latency 6 with FIFO_DEPTH=4 → outstanding+count never exceeds 4; all 8 pixels in order; no FIFO overflow.
- mem_waitrequest high for 3 cycles on address 5 → mem_addr=5 and mem_read held stable; no duplicate or skipped pixel.
- out_ready toggling 1,0,0,1 → shift only on ready cycles; FIFO fills and mem_read deasserts when credits are exhausted; order preserved.
- Reset asserted after 3 shifts, with stale mem_readdatavalid pulses the next 2 cycles → outputs at reset values; stale data dropped; a new start yields pixels from address 0.
- start pulsed while busy → ignored; exactly 8 shifts and a single done.
